alu_exec_stage: RTL and testbench



---
 rtl/arm_pkg.sv | 56 +++++
 rtl/cond_eval.sv | 46 ++++
 rtl/alu_exec_stage.sv | 134 +++++++++++++
 tb/tb_alu_exec_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Constants shared by the ARM execute-stage slice:
//   - data-processing opcodes OP_AND .. OP_MVN
//   - condition codes CC_EQ .. CC_AL plus CC_NV
//   - bit positions of N, Z, C and V inside the 4-bit {N,Z,C,V} register
// The helper is_compare_op() identifies TST/TEQ/CMP/CMN. These opcodes always
// set flags and never write the register file.
// ---------------------------------------------------------------------------
package arm_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_MI = 4'h4;
    localparam logic [3:0] CC_PL = 4'h5;
    localparam logic [3:0] CC_VS = 4'h6;
    localparam logic [3:0] CC_VC = 4'h7;
    localparam logic [3:0] CC_HI = 4'h8;
    localparam logic [3:0] CC_LS = 4'h9;
    localparam logic [3:0] CC_GE = 4'hA;
    localparam logic [3:0] CC_LT = 4'hB;
    localparam logic [3:0] CC_GT = 4'hC;
    localparam logic [3:0] CC_LE = 4'hD;
    localparam logic [3:0] CC_AL = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // TST, TEQ, CMP and CMN occupy opcodes 8..B.
    function automatic logic is_compare_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational ARM condition-code check.
//   cond [3:0] in  : condition field of the instruction
//   nzcv [3:0] in  : current flag register {N,Z,C,V}
//   pass       out : 1 when the instruction should execute
// The code 1111 (NV) never passes.
// ---------------------------------------------------------------------------
module cond_eval
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// ARM data-processing execute stage with a single pipeline register.
//   clk, rst_n         : clock and asynchronous active-low reset
//   in_valid           : inputs carry a real instruction
//   stall              : freeze every register (this takes priority over flush)
//   flush              : discard the instruction being captured
//   cond, opcode, s_bit: condition field, ALU opcode and set-flags bit
//   rn, n_shift        : operand a and the shifted operand b
//   rd_in              : destination register index
//   out_valid, result, rd_out, rf_we, cond_pass : registered writeback info
//   flags              : architectural {N,Z,C,V} register
// ---------------------------------------------------------------------------
module alu_exec_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [31:0] rn,
    input  logic [31:0] n_shift,
    input  logic [3:0]  rd_in,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  rd_out,
    output logic        rf_we,
    output logic        cond_pass,
    output logic [3:0]  flags
);

    logic        pass;
    logic        accept;
    logic        is_arith;
    logic [31:0] add_x, add_y, logic_res, alu_res;
    logic        add_cin;
    logic [32:0] sum33;
    logic [3:0]  new_flags;

    cond_eval u_cond_eval (
        .cond (cond),
        .nzcv (flags),
        .pass (pass)
    );

    assign accept = in_valid && !flush && !stall;

    // All arithmetic goes through a single 33-bit adder. Subtract-type ops
    // add the inverted subtrahend. The carry-out is then the ARM "not borrow".
    always_comb begin
        is_arith  = 1'b0;
        add_x     = rn;
        add_y     = n_shift;
        add_cin   = 1'b0;
        logic_res = 32'h0;
        case (opcode)
            OP_AND, OP_TST: logic_res = rn & n_shift;
            OP_EOR, OP_TEQ: logic_res = rn ^ n_shift;
            OP_ORR:         logic_res = rn | n_shift;
            OP_MOV:         logic_res = n_shift;
            OP_BIC:         logic_res = rn & ~n_shift;
            OP_MVN:         logic_res = ~n_shift;
            OP_SUB, OP_CMP: begin
                is_arith = 1'b1; add_x = rn;      add_y = ~n_shift; add_cin = 1'b1;
            end
            OP_RSB: begin
                is_arith = 1'b1; add_x = n_shift; add_y = ~rn;      add_cin = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1; add_x = rn;      add_y = n_shift;  add_cin = 1'b0;
            end
            OP_ADC: begin
                is_arith = 1'b1; add_x = rn;      add_y = n_shift;  add_cin = flags[FLAG_C];
            end
            OP_SBC: begin
                is_arith = 1'b1; add_x = rn;      add_y = ~n_shift; add_cin = flags[FLAG_C];
            end
            OP_RSC: begin
                is_arith = 1'b1; add_x = n_shift; add_y = ~rn;      add_cin = flags[FLAG_C];
            end
            default: logic_res = 32'h0;
        endcase
    end

    assign sum33   = {1'b0, add_x} + {1'b0, add_y} + {32'h0, add_cin};
    assign alu_res = is_arith ? sum33[31:0] : logic_res;

    // The shifter supplies no carry-out, so logical ops keep C and V. Overflow
    // occurs when both adder inputs have the same sign and the sum's sign differs.
    always_comb begin
        new_flags         = flags;
        new_flags[FLAG_N] = alu_res[31];
        new_flags[FLAG_Z] = (alu_res == 32'h0);
        if (is_arith) begin
            new_flags[FLAG_C] = sum33[32];
            new_flags[FLAG_V] = (add_x[31] == add_y[31]) && (sum33[31] != add_x[31]);
        end
    end

    // Writeback register. On a stall every output holds its value. An idle
    // or flushed cycle clears only the valid and write-enable outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= 32'h0;
            rd_out    <= 4'h0;
            rf_we     <= 1'b0;
            cond_pass <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            rd_out    <= rd_in;
            rf_we     <= pass && !is_compare_op(opcode);
            cond_pass <= pass;
        end else if (!stall) begin
            out_valid <= 1'b0;
            rf_we     <= 1'b0;
        end
    end

    // NZCV register. Compare ops update it even when S is clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (accept && pass && (s_bit || is_compare_op(opcode))) begin
            flags <= new_flags;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
// Self-checking bench for alu_exec_stage. It runs a table of directed vectors,
// a few hand-written sequences (stall, flush, asynchronous reset), and then
// randomized traffic checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;
    import arm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [3:0]  cond, opcode, rd_in;
    logic        s_bit;
    logic [31:0] rn, n_shift;
    logic        out_valid, rf_we, cond_pass;
    logic [31:0] result;
    logic [3:0]  rd_out, flags;

    int checks = 0;
    int errors = 0;

    // Reference state: the outputs the DUT should present after each edge.
    logic        m_valid, m_we, m_pass;
    logic [31:0] m_result;
    logic [3:0]  m_rd, m_flags;

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic [31:0] exp_result;
        logic        exp_we;
        logic        exp_pass;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[16];

    alu_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .cond      (cond),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .rn        (rn),
        .n_shift   (n_shift),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .result    (result),
        .rd_out    (rd_out),
        .rf_we     (rf_we),
        .cond_pass (cond_pass),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Guard against a runaway simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Condition check derived directly from the ARM condition table.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU computed with wide integer arithmetic. Carry is "sum reached 2^32"
    // or "minuend >= subtrahend". Overflow is "true signed result out of range".
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                    input logic [3:0] f,
                                    output logic [31:0] r, output logic [3:0] nf);
        longint ua, ub, sa, sb, full, sfull, cin, bor;
        logic   cy, ov, arith;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = $signed(a);
        sb = $signed(b);
        cin = f[1] ? 1 : 0;
        bor = 1 - cin;
        arith = 1'b1;
        full = 0; sfull = 0; cy = f[1]; ov = f[0];
        case (op)
            OP_ADD, OP_CMN: begin full = ua + ub;       sfull = sa + sb;       cy = full > 64'hFFFFFFFF; end
            OP_ADC:         begin full = ua + ub + cin; sfull = sa + sb + cin; cy = full > 64'hFFFFFFFF; end
            OP_SUB, OP_CMP: begin full = ua - ub;       sfull = sa - sb;       cy = ua >= ub; end
            OP_RSB:         begin full = ub - ua;       sfull = sb - sa;       cy = ub >= ua; end
            OP_SBC:         begin full = ua - ub - bor; sfull = sa - sb - bor; cy = ua >= ub + bor; end
            OP_RSC:         begin full = ub - ua - bor; sfull = sb - sa - bor; cy = ub >= ua + bor; end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            r  = full[31:0];
            ov = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
        end else begin
            case (op)
                OP_AND, OP_TST: r = a & b;
                OP_EOR, OP_TEQ: r = a ^ b;
                OP_ORR:         r = a | b;
                OP_MOV:         r = b;
                OP_BIC:         r = a & ~b;
                default:        r = ~b;
            endcase
        end
        nf = {r[31], (r == 32'h0), cy, ov};
    endfunction

    // Drive one cycle of inputs, wait for the edge, and advance the model.
    task automatic applyStimulus(input logic v, input logic st, input logic fl,
                                 input logic [3:0] cc, input logic [3:0] op,
                                 input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] rd);
        logic        p, cmp;
        logic [31:0] r;
        logic [3:0]  nf;
        in_valid = v; stall = st; flush = fl;
        cond = cc; opcode = op; s_bit = s; rn = a; n_shift = b; rd_in = rd;
        p   = ref_cond(cc, m_flags);
        cmp = (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
        ref_alu(op, a, b, m_flags, r, nf);
        @(posedge clk);
        #1;
        if (!st) begin
            if (v && !fl) begin
                m_valid  = 1'b1;
                m_result = r;
                m_rd     = rd;
                m_pass   = p;
                m_we     = p && !cmp;
                if (p && (s || cmp)) m_flags = nf;
            end else begin
                m_valid = 1'b0;
                m_we    = 1'b0;
            end
        end
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] er,
                               input logic [3:0] erd, input logic ewe,
                               input logic ep, input logic [3:0] ef);
        check1({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, ev});
        check1({tag, ".result"},    result,             er);
        check1({tag, ".rd_out"},    {28'h0, rd_out},    {28'h0, erd});
        check1({tag, ".rf_we"},     {31'h0, rf_we},     {31'h0, ewe});
        check1({tag, ".flags"},     {28'h0, flags},     {28'h0, ef});
        if (ev) check1({tag, ".cond_pass"}, {31'h0, cond_pass}, {31'h0, ep});
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_valid, m_result, m_rd, m_we, m_pass, m_flags);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] specials[6];
        specials[0] = 32'h0;        specials[1] = 32'hFFFFFFFF;
        specials[2] = 32'h7FFFFFFF; specials[3] = 32'h80000000;
        specials[4] = 32'h1;        specials[5] = 32'h80000001;
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 5)];
            1:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Directed vectors in sequence. Flags carry from one entry to the next.
        vecs[0]  = '{CC_AL, OP_ADD, 1, 32'd5,        32'd3,        4'd2,  32'd8,        1, 1, 4'b0000};
        vecs[1]  = '{CC_AL, OP_CMP, 0, 32'd3,        32'd5,        4'd0,  32'hFFFFFFFE, 0, 1, 4'b1000};
        vecs[2]  = '{CC_LT, OP_ADD, 0, 32'd1,        32'd1,        4'd1,  32'd2,        1, 1, 4'b1000};
        vecs[3]  = '{CC_AL, OP_ADD, 1, 32'h7FFFFFFF, 32'd1,        4'd3,  32'h80000000, 1, 1, 4'b1001};
        vecs[4]  = '{CC_AL, OP_ADC, 1, 32'hFFFFFFFF, 32'd0,        4'd4,  32'hFFFFFFFF, 1, 1, 4'b1000};
        vecs[5]  = '{CC_AL, OP_SUB, 1, 32'd5,        32'd5,        4'd5,  32'd0,        1, 1, 4'b0110};
        vecs[6]  = '{CC_EQ, OP_MOV, 1, 32'd9,        32'd0,        4'd6,  32'd0,        1, 1, 4'b0110};
        vecs[7]  = '{CC_NE, OP_ADD, 1, 32'd1,        32'd2,        4'd7,  32'd3,        0, 0, 4'b0110};
        vecs[8]  = '{CC_NV, OP_ADD, 1, 32'd1,        32'd1,        4'd8,  32'd2,        0, 0, 4'b0110};
        vecs[9]  = '{CC_AL, OP_SUB, 1, 32'd2,        32'd3,        4'd9,  32'hFFFFFFFF, 1, 1, 4'b1000};
        vecs[10] = '{CC_AL, OP_ADD, 1, 32'hFFFFFFFF, 32'd1,        4'd10, 32'd0,        1, 1, 4'b0110};
        vecs[11] = '{CC_CS, OP_RSB, 1, 32'd10,       32'd3,        4'd11, 32'hFFFFFFF9, 1, 1, 4'b1000};
        vecs[12] = '{CC_AL, OP_TEQ, 0, 32'hF0,       32'hF0,       4'd12, 32'd0,        0, 1, 4'b0100};
        vecs[13] = '{CC_AL, OP_SBC, 1, 32'd10,       32'd3,        4'd13, 32'd6,        1, 1, 4'b0010};
        vecs[14] = '{CC_AL, OP_BIC, 1, 32'hFF,       32'h0F,       4'd14, 32'hF0,       1, 1, 4'b0010};
        vecs[15] = '{CC_HI, OP_MVN, 1, 32'd0,        32'd0,        4'd15, 32'hFFFFFFFF, 1, 1, 4'b1010};

        // Hold reset with a valid ADD present; nothing may be captured.
        rst_n = 1'b0;
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        cond = CC_AL; opcode = OP_ADD; s_bit = 1'b1;
        rn = 32'd5; n_shift = 32'd3; rd_in = 4'd2;
        m_valid = 0; m_result = 0; m_rd = 0; m_we = 0; m_pass = 0; m_flags = 0;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("reset_hold", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
            check1("reset_hold.cond_pass", {31'h0, cond_pass}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, vecs[i].cond, vecs[i].op, vecs[i].s,
                          vecs[i].a, vecs[i].b, vecs[i].rd);
            checkOutput($sformatf("vec%0d", i), 1'b1, vecs[i].exp_result, vecs[i].rd,
                        vecs[i].exp_we, vecs[i].exp_pass, vecs[i].exp_flags);
        end

        // Stall for two cycles while the inputs change. Everything stays as vec15 left it.
        applyStimulus(1'b1, 1'b1, 1'b0, CC_AL, OP_SUB, 1'b1, 32'd1, 32'd2, 4'd3);
        checkOutput("stall1", 1'b1, 32'hFFFFFFFF, 4'd15, 1'b1, 1'b1, 4'b1010);
        applyStimulus(1'b1, 1'b1, 1'b1, CC_AL, OP_ADD, 1'b1, 32'd7, 32'd7, 4'd4);
        checkOutput("stall2", 1'b1, 32'hFFFFFFFF, 4'd15, 1'b1, 1'b1, 4'b1010);

        // A flushed CMP is dropped and the flags are untouched.
        applyStimulus(1'b1, 1'b0, 1'b1, CC_AL, OP_CMP, 1'b1, 32'd0, 32'd1, 4'd5);
        checkOutput("flush", 1'b0, 32'hFFFFFFFF, 4'd15, 1'b0, 1'b1, 4'b1010);

        // Idle cycle clears valid and write enable but keeps the data.
        applyStimulus(1'b0, 1'b0, 1'b0, CC_AL, OP_ADD, 1'b1, 32'd1, 32'd1, 4'd6);
        checkOutput("idle", 1'b0, 32'hFFFFFFFF, 4'd15, 1'b0, 1'b1, 4'b1010);

        // Produce nonzero outputs, then reset asynchronously between edges.
        applyStimulus(1'b1, 1'b0, 1'b0, CC_AL, OP_ADD, 1'b1, 32'h80000000, 32'h80000001, 4'hC);
        checkOutput("pre_areset", 1'b1, 32'h1, 4'hC, 1'b1, 1'b1, 4'b0011);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        check1("async_reset.cond_pass", {31'h0, cond_pass}, 32'h0);
        m_valid = 0; m_result = 0; m_rd = 0; m_we = 0; m_pass = 0; m_flags = 0;
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, CC_AL, OP_ADD, 1'b0, 32'd20, 32'd22, 4'd1);
        checkOutput("after_reset", 1'b1, 32'd42, 4'd1, 1'b1, 1'b1, 4'b0000);

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic v, st, fl;
            v  = ($urandom_range(0, 7) != 0);
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 7) == 0);
            applyStimulus(v, st, fl, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), pickOperand(), pickOperand(),
                          4'($urandom_range(0, 15)));
            checkModel($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
